// File: rtl/usb_fsi_pkg.sv
// ============================================================================
// usb_fsi_pkg : shared word type and widths for the FSI FIFO stage
// Revision    : 1.0
// ============================================================================
`default_nettype none

package usb_fsi_pkg;

  localparam int FSI_WORD_W = 9;

  typedef struct packed {
    logic       channel;
    logic [7:0] data;
  } fsi_word_t;

endpackage

`default_nettype wire

// File: rtl/usb_fsi_fifo_sync.sv
// ============================================================================
// usb_fsi_fifo_sync : show-ahead synchronous FIFO, pointer-MSB full/empty
// Revision          : 1.0
// ============================================================================
`default_nettype none

module usb_fsi_fifo_sync
  import usb_fsi_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5,
  parameter int WIDTH      = FSI_WORD_W
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_push_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_push_ok,
  output logic                  o_pop_ok
);

  localparam int c_DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    r_mem [c_DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;

  assign o_empty  = (r_wr_ptr == r_rd_ptr);
  assign o_full   = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                    (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign o_count  = r_wr_ptr - r_rd_ptr;
  assign o_head   = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  // A pop in the same cycle frees the slot the push lands in, so full+pop still accepts.
  assign o_pop_ok  = i_pop && !o_empty;
  assign o_push_ok = i_push && (!o_full || o_pop_ok);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (o_push_ok) r_wr_ptr <= r_wr_ptr + (DEPTH_LOG2+1)'(1);
      if (o_pop_ok)  r_rd_ptr <= r_rd_ptr + (DEPTH_LOG2+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (o_push_ok && !i_flush && !i_reset) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_push_data;
  end

endmodule

`default_nettype wire

// File: rtl/usb_fsi_fifo.sv
// ============================================================================
// usb_fsi_fifo : RX/TX buffering between FTDI fast-serial PHY and USB logic
// Optional     : USB_FSI_FIFO_OVERFLOW_EN enables the sticky o_rx_overflow flag
// Revision     : 1.0
// ============================================================================
`default_nettype none

module usb_fsi_fifo
  import usb_fsi_pkg::*;
#(
  parameter int RX_DEPTH_LOG2 = 5,
  parameter int TX_DEPTH_LOG2 = 5,
  parameter int RX_SLACK      = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_flush,
  output logic       o_phy_rx_ready,
  input  logic       i_phy_rx_valid,
  input  logic       i_phy_rx_channel,
  input  logic [7:0] i_phy_rx_data,
  input  logic       i_phy_tx_busy,
  output logic       o_phy_tx_valid,
  output logic       o_phy_tx_channel,
  output logic [7:0] o_phy_tx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_rx_channel,
  output logic [7:0] o_rx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  input  logic       i_tx_channel,
  input  logic [7:0] i_tx_data,
  output logic       o_rx_overflow
);

  localparam int c_RX_LIMIT = (1 << RX_DEPTH_LOG2) - RX_SLACK;

  fsi_word_t              w_rx_in, w_rx_head, w_tx_in, w_tx_head;
  logic                   w_rx_empty, w_rx_push_ok, w_rx_pop_ok, w_rx_full_unused;
  logic                   w_tx_empty, w_tx_full, w_tx_pop;
  logic                   w_tx_push_ok_unused, w_tx_pop_ok_unused;
  logic [RX_DEPTH_LOG2:0] w_rx_count, w_rx_count_next;
  logic [TX_DEPTH_LOG2:0] w_tx_count_unused;
  logic                   r_rx_ready;

  assign w_rx_in = {i_phy_rx_channel, i_phy_rx_data};
  assign w_tx_in = {i_tx_channel, i_tx_data};

  usb_fsi_fifo_sync #(
    .DEPTH_LOG2 (RX_DEPTH_LOG2),
    .WIDTH      (FSI_WORD_W)
  ) u_rx_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_flush     (i_flush),
    .i_push      (i_phy_rx_valid),
    .i_push_data (w_rx_in),
    .i_pop       (i_rx_ready),
    .o_head      (w_rx_head),
    .o_full      (w_rx_full_unused),
    .o_empty     (w_rx_empty),
    .o_count     (w_rx_count),
    .o_push_ok   (w_rx_push_ok),
    .o_pop_ok    (w_rx_pop_ok)
  );

  usb_fsi_fifo_sync #(
    .DEPTH_LOG2 (TX_DEPTH_LOG2),
    .WIDTH      (FSI_WORD_W)
  ) u_tx_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_flush     (i_flush),
    .i_push      (i_tx_valid),
    .i_push_data (w_tx_in),
    .i_pop       (w_tx_pop),
    .o_head      (w_tx_head),
    .o_full      (w_tx_full),
    .o_empty     (w_tx_empty),
    .o_count     (w_tx_count_unused),
    .o_push_ok   (w_tx_push_ok_unused),
    .o_pop_ok    (w_tx_pop_ok_unused)
  );

  assign o_rx_valid   = !w_rx_empty;
  assign o_rx_channel = w_rx_head.channel;
  assign o_rx_data    = w_rx_head.data;
  assign o_tx_ready   = !w_tx_full;

  // Reset drops the PHY-facing valid/ready in the same cycle it is asserted.
  assign o_phy_tx_valid   = !w_tx_empty && !i_reset;
  assign o_phy_tx_channel = w_tx_head.channel;
  assign o_phy_tx_data    = w_tx_head.data;
  assign w_tx_pop         = o_phy_tx_valid && !i_phy_tx_busy;

  always_comb begin
    w_rx_count_next = w_rx_count;
    if (w_rx_push_ok && !w_rx_pop_ok)
      w_rx_count_next = w_rx_count + (RX_DEPTH_LOG2+1)'(1);
    else if (w_rx_pop_ok && !w_rx_push_ok)
      w_rx_count_next = w_rx_count - (RX_DEPTH_LOG2+1)'(1);
  end

  // Ready looks at post-update occupancy so a byte strobed one cycle after ready falls still fits.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush)
      r_rx_ready <= 1'b1;
    else
      r_rx_ready <= (32'(w_rx_count_next) <= c_RX_LIMIT);
  end

  assign o_phy_rx_ready = r_rx_ready && !i_reset;

`ifdef USB_FSI_FIFO_OVERFLOW_EN
  logic r_rx_overflow;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush)
      r_rx_overflow <= 1'b0;
    else if (i_phy_rx_valid && !w_rx_push_ok)
      r_rx_overflow <= 1'b1;
  end

  assign o_rx_overflow = r_rx_overflow;
`else
  assign o_rx_overflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_usb_fsi_fifo.sv
// ============================================================================
// tb_usb_fsi_fifo : directed vector table plus hand sequences for usb_fsi_fifo
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_usb_fsi_fifo;

`ifdef USB_FSI_FIFO_OVERFLOW_EN
  localparam logic c_OVF_EN = 1'b1;
`else
  localparam logic c_OVF_EN = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset, i_flush;
  logic       o_phy_rx_ready, i_phy_rx_valid, i_phy_rx_channel;
  logic [7:0] i_phy_rx_data;
  logic       i_phy_tx_busy, o_phy_tx_valid, o_phy_tx_channel;
  logic [7:0] o_phy_tx_data;
  logic       o_rx_valid, i_rx_ready, o_rx_channel;
  logic [7:0] o_rx_data;
  logic       i_tx_valid, o_tx_ready, i_tx_channel;
  logic [7:0] i_tx_data;
  logic       o_rx_overflow;

  int n_chk = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  usb_fsi_fifo #(
    .RX_DEPTH_LOG2 (5),
    .TX_DEPTH_LOG2 (5),
    .RX_SLACK      (2)
  ) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_flush          (i_flush),
    .o_phy_rx_ready   (o_phy_rx_ready),
    .i_phy_rx_valid   (i_phy_rx_valid),
    .i_phy_rx_channel (i_phy_rx_channel),
    .i_phy_rx_data    (i_phy_rx_data),
    .i_phy_tx_busy    (i_phy_tx_busy),
    .o_phy_tx_valid   (o_phy_tx_valid),
    .o_phy_tx_channel (o_phy_tx_channel),
    .o_phy_tx_data    (o_phy_tx_data),
    .o_rx_valid       (o_rx_valid),
    .i_rx_ready       (i_rx_ready),
    .o_rx_channel     (o_rx_channel),
    .o_rx_data        (o_rx_data),
    .i_tx_valid       (i_tx_valid),
    .o_tx_ready       (o_tx_ready),
    .i_tx_channel     (i_tx_channel),
    .i_tx_data        (i_tx_data),
    .o_rx_overflow    (o_rx_overflow)
  );

  typedef struct {
    logic       flush, prv, pch;
    logic [7:0] pdat;
    logic       rrdy, tval, tch;
    logic [7:0] tdat;
    logic       busy;
    logic       e_rxv;
    logic [8:0] e_rx;
    logic       e_prr, e_txv;
    logic [8:0] e_tx;
    logic       e_txr;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_flush = 0; i_phy_rx_valid = 0; i_phy_rx_channel = 0; i_phy_rx_data = 0;
    i_rx_ready = 0; i_tx_valid = 0; i_tx_channel = 0; i_tx_data = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] exp_q [$];
    logic       accept;
    int         got, bc;

    //          fl prv pch pdat  rr tv tch tdat  bsy | rxv e_rx     prr txv e_tx     txr
    vecs[0]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0,   0, 9'h000,   1,  0, 9'h000,   1};
    vecs[1]  = '{0, 1, 0, 8'h11, 1, 0, 0, 8'h00, 0,   1, 9'h011,   1,  0, 9'h000,   1};
    vecs[2]  = '{0, 1, 1, 8'h22, 1, 0, 0, 8'h00, 0,   1, 9'h122,   1,  0, 9'h000,   1};
    vecs[3]  = '{0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0,   0, 9'h000,   1,  0, 9'h000,   1};
    vecs[4]  = '{0, 0, 0, 8'h00, 0, 1, 1, 8'hA5, 0,   0, 9'h000,   1,  1, 9'h1A5,   1};
    vecs[5]  = '{0, 0, 0, 8'h00, 0, 1, 0, 8'h3C, 0,   0, 9'h000,   1,  1, 9'h03C,   1};
    vecs[6]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1,   0, 9'h000,   1,  1, 9'h03C,   1};
    vecs[7]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1,   0, 9'h000,   1,  1, 9'h03C,   1};
    vecs[8]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0,   0, 9'h000,   1,  0, 9'h000,   1};
    vecs[9]  = '{0, 1, 1, 8'h7E, 0, 0, 0, 8'h00, 0,   1, 9'h17E,   1,  0, 9'h000,   1};
    vecs[10] = '{0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0,   0, 9'h000,   1,  0, 9'h000,   1};
    vecs[11] = '{0, 1, 0, 8'h55, 0, 1, 1, 8'h99, 1,   1, 9'h055,   1,  1, 9'h199,   1};
    vecs[12] = '{1, 1, 1, 8'h66, 0, 1, 1, 8'h77, 1,   0, 9'h000,   1,  0, 9'h000,   1};
    vecs[13] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0,   0, 9'h000,   1,  0, 9'h000,   1};

    // Reset
    idle();
    i_phy_tx_busy = 0;
    i_reset = 1;
    tick();
    chk("rst_phy_rx_ready_low", 32'(o_phy_rx_ready), 0);
    chk("rst_phy_tx_valid", 32'(o_phy_tx_valid), 0);
    tick();
    i_reset = 0;
    #1;
    chk("rst_rx_valid", 32'(o_rx_valid), 0);
    chk("rst_tx_ready", 32'(o_tx_ready), 1);
    chk("rst_phy_rx_ready_after", 32'(o_phy_rx_ready), 1);
    chk("rst_overflow", 32'(o_rx_overflow), 0);

    // Vector table
    for (int i = 0; i < 14; i++) begin
      i_flush = vecs[i].flush; i_phy_rx_valid = vecs[i].prv;
      i_phy_rx_channel = vecs[i].pch; i_phy_rx_data = vecs[i].pdat;
      i_rx_ready = vecs[i].rrdy; i_tx_valid = vecs[i].tval;
      i_tx_channel = vecs[i].tch; i_tx_data = vecs[i].tdat;
      i_phy_tx_busy = vecs[i].busy;
      tick();
      chk($sformatf("v%0d_rx_valid", i), 32'(o_rx_valid), 32'(vecs[i].e_rxv));
      if (vecs[i].e_rxv)
        chk($sformatf("v%0d_rx_word", i), 32'({o_rx_channel, o_rx_data}), 32'(vecs[i].e_rx));
      chk($sformatf("v%0d_phy_rx_ready", i), 32'(o_phy_rx_ready), 32'(vecs[i].e_prr));
      chk($sformatf("v%0d_phy_tx_valid", i), 32'(o_phy_tx_valid), 32'(vecs[i].e_txv));
      if (vecs[i].e_txv)
        chk($sformatf("v%0d_tx_word", i), 32'({o_phy_tx_channel, o_phy_tx_data}), 32'(vecs[i].e_tx));
      chk($sformatf("v%0d_tx_ready", i), 32'(o_tx_ready), 32'(vecs[i].e_txr));
    end
    idle();
    i_phy_tx_busy = 0;

    // RX fill to full: ready falls once fewer than 2 slots remain
    for (int k = 0; k < 32; k++) begin
      i_phy_rx_valid = 1; i_phy_rx_channel = k[0]; i_phy_rx_data = 8'(k);
      tick();
      chk($sformatf("fill%0d_phy_rx_ready", k + 1), 32'(o_phy_rx_ready), (k + 1 <= 30) ? 1 : 0);
    end
    // Full: pop and PHY push together
    i_phy_rx_channel = 0; i_phy_rx_data = 8'h40; i_rx_ready = 1;
    #1;
    chk("full_head_before_pop", 32'({o_rx_channel, o_rx_data}), 32'h000);
    tick();
    chk("full_poppush_overflow", 32'(o_rx_overflow), 0);
    chk("full_poppush_ready", 32'(o_phy_rx_ready), 0);
    // Push while full without pop: dropped
    i_rx_ready = 0; i_phy_rx_channel = 1; i_phy_rx_data = 8'hEE;
    tick();
    chk("drop_overflow", 32'(o_rx_overflow), 32'(c_OVF_EN));
    i_phy_rx_valid = 0;
    tick();
    exp_q = {};
    for (int k = 1; k < 32; k++) exp_q.push_back({k[0], 8'(k)});
    exp_q.push_back(9'h040);
    i_rx_ready = 1;
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("drain%0d_valid", k), 32'(o_rx_valid), 1);
      chk($sformatf("drain%0d_word", k), 32'({o_rx_channel, o_rx_data}), 32'(exp_q[k]));
      tick();
    end
    chk("drain_empty", 32'(o_rx_valid), 0);
    chk("drain_ready", 32'(o_phy_rx_ready), 1);
    i_rx_ready = 0;

    // Flush with both FIFOs half full and a simultaneous push
    i_phy_tx_busy = 1;
    for (int k = 0; k < 16; k++) begin
      i_phy_rx_valid = 1; i_phy_rx_channel = 1; i_phy_rx_data = 8'(8'h80 + k);
      i_tx_valid = 1; i_tx_channel = 0; i_tx_data = 8'(k);
      tick();
    end
    chk("pre_flush_rx_valid", 32'(o_rx_valid), 1);
    chk("pre_flush_tx_valid", 32'(o_phy_tx_valid), 1);
    i_flush = 1;
    tick();
    idle();
    chk("flush_rx_valid", 32'(o_rx_valid), 0);
    chk("flush_tx_valid", 32'(o_phy_tx_valid), 0);
    chk("flush_tx_ready", 32'(o_tx_ready), 1);
    chk("flush_overflow", 32'(o_rx_overflow), 0);
    chk("flush_phy_rx_ready", 32'(o_phy_rx_ready), 1);
    tick();
    chk("flush_discard_rx", 32'(o_rx_valid), 0);
    chk("flush_discard_tx", 32'(o_phy_tx_valid), 0);

    // TX fill with busy held, then drain through a busy PHY model, 3 passes
    for (int p = 0; p < 3; p++) begin
      i_phy_tx_busy = 1;
      exp_q = {};
      for (int k = 0; k < 32; k++) begin
        i_tx_valid = 1; i_tx_channel = k[1]; i_tx_data = 8'(p * 50 + k);
        exp_q.push_back({k[1], 8'(p * 50 + k)});
        tick();
        chk($sformatf("p%0d_fill%0d_tx_ready", p, k + 1), 32'(o_tx_ready), (k + 1 < 32) ? 1 : 0);
      end
      i_tx_valid = 0;
      i_phy_tx_busy = 0;
      bc = 0;
      got = 0;
      for (int c = 0; c < 400 && got < 32; c++) begin
        accept = o_phy_tx_valid && !i_phy_tx_busy;
        if (accept) begin
          chk($sformatf("p%0d_tx%0d", p, got), 32'({o_phy_tx_channel, o_phy_tx_data}), 32'(exp_q[got]));
          got++;
        end
        tick();
        if (accept) begin
          i_phy_tx_busy = 1; bc = 2;
        end else if (bc > 0) begin
          bc--;
          if (bc == 0) i_phy_tx_busy = 0;
        end
      end
      chk($sformatf("p%0d_drain_count", p), 32'(got), 32);
      chk($sformatf("p%0d_drain_empty", p), 32'(o_phy_tx_valid), 0);
    end

    // Single byte, PHY busy for 20 cycles after accepting it
    i_phy_tx_busy = 0;
    tick(); tick();
    i_tx_valid = 1; i_tx_channel = 1; i_tx_data = 8'hA5;
    tick();
    chk("a5_valid", 32'(o_phy_tx_valid), 1);
    chk("a5_word", 32'({o_phy_tx_channel, o_phy_tx_data}), 32'h1A5);
    i_tx_channel = 0; i_tx_data = 8'h5A;
    tick();
    i_tx_valid = 0;
    i_phy_tx_busy = 1;
    for (int c = 0; c < 20; c++) tick();
    chk("busy_hold_valid", 32'(o_phy_tx_valid), 1);
    chk("busy_hold_word", 32'({o_phy_tx_channel, o_phy_tx_data}), 32'h05A);
    i_phy_tx_busy = 0;
    tick();
    chk("busy_release_popped", 32'(o_phy_tx_valid), 0);

    // Reset mid-transfer
    i_phy_tx_busy = 1;
    i_tx_valid = 1; i_tx_channel = 1; i_tx_data = 8'hC3;
    i_phy_rx_valid = 1; i_phy_rx_data = 8'h12;
    tick();
    idle();
    chk("midrst_pre_valid", 32'(o_phy_tx_valid), 1);
    i_reset = 1;
    #1;
    chk("midrst_tx_valid_now", 32'(o_phy_tx_valid), 0);
    chk("midrst_rx_ready_now", 32'(o_phy_rx_ready), 0);
    tick();
    i_reset = 0;
    #1;
    chk("postrst_tx_valid", 32'(o_phy_tx_valid), 0);
    chk("postrst_rx_valid", 32'(o_rx_valid), 0);
    chk("postrst_rx_ready", 32'(o_phy_rx_ready), 1);
    chk("postrst_tx_ready", 32'(o_tx_ready), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
